// File: rtl/inst_issue_queue.sv
// inst_issue_queue: in-order instruction queue between fetch return and the
// dual-issue decoders. Accepts up to two fetched words per cycle, presents the
// two oldest entries, and retires one or two entries per cycle.
// Optional feature macro: IQ_REDIRECT_MATCH_EN. When defined, a redirect arms a
// PC matcher that discards stale fetch returns until the redirect target arrives.
module inst_issue_queue #(
  parameter int DEPTH       = 16,
  parameter int INST_W      = 32,
  parameter int PC_W        = 32,
  parameter int FULL_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     redirect_i,
  input  logic [PC_W-1:0]          redirect_pc_i,
  input  logic [1:0]               push_valid_i,
  input  logic [INST_W-1:0]        push_inst0_i,
  input  logic [INST_W-1:0]        push_inst1_i,
  input  logic [PC_W-1:0]          push_pc0_i,
  input  logic [PC_W-1:0]          push_pc1_i,
  input  logic                     pop_en_i,
  input  logic                     pop_dual_i,
  input  logic                     stall_i,
  output logic [1:0]               head_valid_o,
  output logic [INST_W-1:0]        head_inst0_o,
  output logic [INST_W-1:0]        head_inst1_o,
  output logic [PC_W-1:0]          head_pc0_o,
  output logic [PC_W-1:0]          head_pc1_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  output logic                     match_armed_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_next_idx;
  logic [AW-1:0] tail_next_idx;
  logic [CW-1:0] count;
  logic          overflow;
  logic          flush;

  logic [1:0]        cand;
  logic [CW-1:0]     n_cand;
  logic [CW-1:0]     space;
  logic [CW-1:0]     n_push;
  logic [CW-1:0]     n_pop;
  logic              dropped;
  logic [INST_W-1:0] first_inst;
  logic [PC_W-1:0]   first_pc;

  // Redirect and flush both empty the queue; the matcher only differs in arming.
  assign flush         = flush_i | redirect_i;
  assign head_next_idx = head + AW'(1);
  assign tail_next_idx = tail + AW'(1);

`ifdef IQ_REDIRECT_MATCH_EN
  logic            armed;
  logic [PC_W-1:0] target;
  logic            match_hit;

  // While armed, discard slots older than the first one carrying the target PC.
  always_comb begin
    cand      = push_valid_i;
    match_hit = 1'b0;
    if (armed) begin
      if (push_valid_i[0] && (push_pc0_i == target)) begin
        cand      = push_valid_i;
        match_hit = 1'b1;
      end else if (push_valid_i[1] && (push_pc1_i == target)) begin
        cand      = 2'b10;
        match_hit = 1'b1;
      end else begin
        cand      = 2'b00;
      end
    end else begin
      cand = push_valid_i;
    end
  end

  // Arm on redirect (re-latching the target), disarm on plain flush or on a match.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed  <= 1'b0;
      target <= {PC_W{1'b0}};
    end else if (redirect_i) begin
      armed  <= 1'b1;
      target <= redirect_pc_i;
    end else if (flush_i) begin
      armed  <= 1'b0;
    end else if (match_hit) begin
      armed  <= 1'b0;
    end
  end

  assign match_armed_o = armed;
`else
  logic unused_redirect_pc;

  assign cand               = push_valid_i;
  assign match_armed_o      = 1'b0;
  assign unused_redirect_pc = ^redirect_pc_i;
`endif

  // Count candidates, clamp to free space before this cycle's pop, clamp pops to count.
  always_comb begin
    n_cand  = CW'(cand[0]) + CW'(cand[1]);
    space   = CW'(DEPTH) - count;
    n_push  = (n_cand > space) ? space : n_cand;
    dropped = (n_cand > space);
    n_pop   = CW'(0);
    if (pop_en_i && !stall_i) begin
      n_pop = pop_dual_i ? CW'(2) : CW'(1);
    end else begin
      n_pop = CW'(0);
    end
    if (n_pop > count) begin
      n_pop = count;
    end else begin
      n_pop = n_pop;
    end
  end

  // Compaction: the oldest valid candidate goes to the tail; slot 1 follows only when both are valid.
  always_comb begin
    if (cand[0]) begin
      first_inst = push_inst0_i;
      first_pc   = push_pc0_i;
    end else begin
      first_inst = push_inst1_i;
      first_pc   = push_pc1_i;
    end
  end

  // Storage writes at tail and tail+1 (wrapping); storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (n_push >= CW'(1)) begin
        inst_mem[tail] <= first_inst;
        pc_mem[tail]   <= first_pc;
      end
      if (n_push == CW'(2)) begin
        inst_mem[tail_next_idx] <= push_inst1_i;
        pc_mem[tail_next_idx]   <= push_pc1_i;
      end
    end
  end

  // Pointer, occupancy and sticky overflow state; flush outranks push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= AW'(0);
      tail     <= AW'(0);
      count    <= CW'(0);
      overflow <= 1'b0;
    end else if (flush) begin
      head     <= AW'(0);
      tail     <= AW'(0);
      count    <= CW'(0);
      overflow <= 1'b0;
    end else begin
      head  <= head + n_pop[AW-1:0];
      tail  <= tail + n_push[AW-1:0];
      count <= count - n_pop + n_push;
      if (dropped) begin
        overflow <= 1'b1;
      end
    end
  end

  assign head_valid_o = {count >= CW'(2), count >= CW'(1)};
  assign count_o      = count;
  assign full_o       = (count >= CW'(DEPTH - FULL_MARGIN));
  assign empty_o      = (count == CW'(0));
  assign overflow_o   = overflow;

  // Head read-out at head and head+1; invalid positions read as zero.
  always_comb begin
    if (head_valid_o[0]) begin
      head_inst0_o = inst_mem[head];
      head_pc0_o   = pc_mem[head];
    end else begin
      head_inst0_o = {INST_W{1'b0}};
      head_pc0_o   = {PC_W{1'b0}};
    end
    if (head_valid_o[1]) begin
      head_inst1_o = inst_mem[head_next_idx];
      head_pc1_o   = pc_mem[head_next_idx];
    end else begin
      head_inst1_o = {INST_W{1'b0}};
      head_pc1_o   = {PC_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// tb_inst_issue_queue: directed scenarios plus randomized traffic against a
// queue-based behavioural model of inst_issue_queue (DEPTH=16, FULL_MARGIN=2).
// Honors IQ_REDIRECT_MATCH_EN the same way as the design.
module tb_inst_issue_queue;

  localparam int DEPTH       = 16;
  localparam int FULL_MARGIN = 2;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [1:0]  push_valid_i;
  logic [31:0] push_inst0_i;
  logic [31:0] push_inst1_i;
  logic [31:0] push_pc0_i;
  logic [31:0] push_pc1_i;
  logic        pop_en_i;
  logic        pop_dual_i;
  logic        stall_i;
  logic [1:0]  head_valid_o;
  logic [31:0] head_inst0_o;
  logic [31:0] head_inst1_o;
  logic [31:0] head_pc0_o;
  logic [31:0] head_pc1_o;
  logic [4:0]  count_o;
  logic        full_o;
  logic        empty_o;
  logic        overflow_o;
  logic        match_armed_o;

  inst_issue_queue #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32), .FULL_MARGIN(FULL_MARGIN)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .push_valid_i(push_valid_i),
    .push_inst0_i(push_inst0_i), .push_inst1_i(push_inst1_i),
    .push_pc0_i(push_pc0_i), .push_pc1_i(push_pc1_i),
    .pop_en_i(pop_en_i), .pop_dual_i(pop_dual_i), .stall_i(stall_i),
    .head_valid_o(head_valid_o), .head_inst0_o(head_inst0_o), .head_inst1_o(head_inst1_o),
    .head_pc0_o(head_pc0_o), .head_pc1_o(head_pc1_o), .count_o(count_o),
    .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o),
    .match_armed_o(match_armed_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Model state: the queue contents in order, oldest first.
  logic [31:0] m_pc[$];
  logic [31:0] m_inst[$];
  bit          m_ovf    = 1'b0;
  bit          m_armed  = 1'b0;
  logic [31:0] m_target = 32'h0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Advance the model by one clock using the inputs the DUT sees at this edge.
  task automatic model_update();
    logic [31:0] cp[$];
    logic [31:0] ci[$];
    int free;
    int popn;
    if (rst) begin
      m_pc.delete(); m_inst.delete();
      m_ovf = 1'b0; m_armed = 1'b0; m_target = 32'h0;
      return;
    end
    if (flush_i || redirect_i) begin
      m_pc.delete(); m_inst.delete();
      m_ovf = 1'b0;
`ifdef IQ_REDIRECT_MATCH_EN
      if (redirect_i) begin
        m_armed = 1'b1; m_target = redirect_pc_i;
      end else begin
        m_armed = 1'b0;
      end
`endif
      return;
    end
    if (push_valid_i[0]) begin cp.push_back(push_pc0_i); ci.push_back(push_inst0_i); end
    if (push_valid_i[1]) begin cp.push_back(push_pc1_i); ci.push_back(push_inst1_i); end
`ifdef IQ_REDIRECT_MATCH_EN
    if (m_armed) begin
      while (cp.size() > 0 && cp[0] != m_target) begin
        void'(cp.pop_front()); void'(ci.pop_front());
      end
      if (cp.size() > 0) m_armed = 1'b0;
    end
`endif
    free = DEPTH - m_pc.size();
    popn = (pop_en_i && !stall_i) ? (pop_dual_i ? 2 : 1) : 0;
    if (popn > m_pc.size()) popn = m_pc.size();
    repeat (popn) begin
      void'(m_pc.pop_front()); void'(m_inst.pop_front());
    end
    for (int i = 0; i < cp.size(); i++) begin
      if (i < free) begin
        m_pc.push_back(cp[i]); m_inst.push_back(ci[i]);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    int sz;
    if (cmp_en) begin
      sz = m_pc.size();
      chk("count", 64'(count_o), 64'(sz));
      chk("empty", 64'(empty_o), 64'(sz == 0));
      chk("full", 64'(full_o), 64'(sz >= DEPTH - FULL_MARGIN));
      chk("head_valid", 64'(head_valid_o), 64'({sz >= 2, sz >= 1}));
      chk("overflow", 64'(overflow_o), 64'(m_ovf));
      chk("armed", 64'(match_armed_o), 64'(m_armed));
      if (sz >= 1) begin
        chk("inst0", 64'(head_inst0_o), 64'(m_inst[0]));
        chk("pc0", 64'(head_pc0_o), 64'(m_pc[0]));
      end else begin
        chk("inst0_zero", 64'(head_inst0_o), 64'h0);
        chk("pc0_zero", 64'(head_pc0_o), 64'h0);
      end
      if (sz >= 2) begin
        chk("inst1", 64'(head_inst1_o), 64'(m_inst[1]));
        chk("pc1", 64'(head_pc1_o), 64'(m_pc[1]));
      end else begin
        chk("inst1_zero", 64'(head_inst1_o), 64'h0);
        chk("pc1_zero", 64'(head_pc1_o), 64'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    push_valid_i = 2'b00; push_inst0_i = 32'h0; push_inst1_i = 32'h0;
    push_pc0_i = 32'h0; push_pc1_i = 32'h0;
    pop_en_i = 1'b0; pop_dual_i = 1'b0; stall_i = 1'b0;
  endtask

  task automatic push2(input logic [31:0] p0, input logic [31:0] p1);
    idle();
    push_valid_i = 2'b11; push_pc0_i = p0; push_pc1_i = p1;
    push_inst0_i = $urandom; push_inst1_i = $urandom;
    step(); idle();
  endtask

  task automatic push1(input logic [31:0] p0);
    idle();
    push_valid_i = 2'b01; push_pc0_i = p0; push_inst0_i = $urandom;
    step(); idle();
  endtask

  task automatic pop(input logic dual);
    idle();
    pop_en_i = 1'b1; pop_dual_i = dual;
    step(); idle();
  endtask

  task automatic do_flush();
    idle(); flush_i = 1'b1; step(); idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    cmp_en = 1'b1;
    step();
    idle();
    step();
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_valid", 64'(head_valid_o), 64'd0);
    chk("rst_pc0", 64'(head_pc0_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_armed", 64'(match_armed_o), 64'd0);

    // Fill and drain.
    for (int k = 0; k < 7; k++) push2(32'h100 + 32'(8 * k), 32'h104 + 32'(8 * k));
    chk("fill_count", 64'(count_o), 64'd14);
    chk("fill_full", 64'(full_o), 64'd1);
    for (int k = 0; k < 7; k++) begin
      chk("drain_pc0", 64'(head_pc0_o), 64'(32'h100 + 32'(8 * k)));
      chk("drain_pc1", 64'(head_pc1_o), 64'(32'h104 + 32'(8 * k)));
      pop(1'b1);
    end
    chk("drain_empty", 64'(empty_o), 64'd1);

    // Overflow at count 15 (also straddles the wrap point).
    for (int k = 0; k < 7; k++) push2(32'h600 + 32'(8 * k), 32'h604 + 32'(8 * k));
    push1(32'h638);
    chk("ovf_pre_count", 64'(count_o), 64'd15);
    push2(32'h640, 32'h644);
    chk("ovf_count", 64'(count_o), 64'd16);
    chk("ovf_flag", 64'(overflow_o), 64'd1);
    pop(1'b0);
    chk("ovf_sticky", 64'(overflow_o), 64'd1);

    // Flush together with push and pop.
    idle();
    flush_i = 1'b1; push_valid_i = 2'b11; push_pc0_i = 32'hAA0; push_pc1_i = 32'hAA4;
    pop_en_i = 1'b1;
    step(); idle();
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_ovf", 64'(overflow_o), 64'd0);
    chk("flush_valid", 64'(head_valid_o), 64'd0);

    // Stall blocks pops.
    push1(32'h700);
    idle(); pop_en_i = 1'b1; stall_i = 1'b1; step(); idle();
    chk("stall_count", 64'(count_o), 64'd1);
    chk("stall_pc0", 64'(head_pc0_o), 64'h700);

    // Odd pop: dual pop with one entry.
    do_flush();
    push1(32'h200);
    chk("odd_pc0", 64'(head_pc0_o), 64'h200);
    pop(1'b1);
    chk("odd_count", 64'(count_o), 64'd0);
    chk("odd_valid", 64'(head_valid_o), 64'd0);

    // Walk both pointers to index 15 then straddle the boundary.
    do_flush();
    push1(32'h0);
    for (int k = 0; k < 14; k++) begin
      idle();
      push_valid_i = 2'b01; push_pc0_i = 32'h4 * 32'(k + 1); push_inst0_i = $urandom;
      pop_en_i = 1'b1;
      step(); idle();
    end
    pop(1'b0);
    chk("wrap_pre_empty", 64'(empty_o), 64'd1);
    push2(32'h300, 32'h304);
    chk("wrap_pc0", 64'(head_pc0_o), 64'h300);
    chk("wrap_pc1", 64'(head_pc1_o), 64'h304);
    pop(1'b1);
    chk("wrap_empty", 64'(empty_o), 64'd1);

    // Redirect behaviour.
    push2(32'h900, 32'h904);
    idle(); redirect_i = 1'b1; redirect_pc_i = 32'h404; step(); idle();
    chk("redir_count", 64'(count_o), 64'd0);
`ifdef IQ_REDIRECT_MATCH_EN
    chk("redir_armed", 64'(match_armed_o), 64'd1);
    push2(32'h500, 32'h504);
    chk("stale_count", 64'(count_o), 64'd0);
    chk("stale_armed", 64'(match_armed_o), 64'd1);
    chk("stale_ovf", 64'(overflow_o), 64'd0);
    push2(32'h400, 32'h404);
    chk("match_count", 64'(count_o), 64'd1);
    chk("match_armed", 64'(match_armed_o), 64'd0);
    chk("match_pc0", 64'(head_pc0_o), 64'h404);
`else
    chk("redir_armed", 64'(match_armed_o), 64'd0);
    push2(32'h500, 32'h504);
    chk("redir_push_count", 64'(count_o), 64'd2);
    chk("redir_push_pc0", 64'(head_pc0_o), 64'h500);
`endif

    // Randomized traffic with phases of light and heavy popping.
    for (int c = 0; c < 4000; c++) begin
      idle();
      rst           = ($urandom_range(0, 999) == 0);
      flush_i       = ($urandom_range(0, 99) == 0);
      redirect_i    = ($urandom_range(0, 59) == 0);
      redirect_pc_i = 32'h400 + 32'(4 * $urandom_range(0, 3));
      push_valid_i  = 2'($urandom_range(0, 3));
      push_pc0_i    = 32'h400 + 32'(4 * $urandom_range(0, 3));
      push_pc1_i    = 32'h400 + 32'(4 * $urandom_range(0, 3));
      push_inst0_i  = $urandom;
      push_inst1_i  = $urandom;
      pop_en_i      = ($urandom_range(0, 99) < (((c / 400) % 2 == 1) ? 85 : 30));
      pop_dual_i    = 1'($urandom_range(0, 1));
      stall_i       = ($urandom_range(0, 7) == 0);
      step();
    end
    idle();
    step();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
